// File: rtl/spike_event_packer.sv
// spike_event_packer
//   Stamps per-channel spike detections with the current frame number and
//   channel index. Accepted events are buffered in a first-word-fall-through
//   FIFO and emitted as 64-bit words on a valid/ready stream. Each frame may
//   accept at most MAX_EVT_PER_FRAME events. Events that cannot be accepted
//   are counted in a saturating drop counter. The next word that is written
//   carries a flag for the cause of the drop.
//
//   Event word: [63:32] frame_No, [31:24] ch_idx, [23:18] 0,
//               [17] limit drop pending, [16] full drop pending,
//               [15:0] spk_amp
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   ch_idx        channel slot of the current sample (NUM_CH = frame marker)
//   ch_valid      ch_idx/spk_flag/spk_amp valid this cycle
//   spk_flag      spike detected on ch_idx
//   spk_amp       signed peak amplitude of the spike
//   frame_No      current frame number from the frame counter
//   m_data        head-of-FIFO event word (zero while empty)
//   m_valid       FIFO non-empty
//   m_ready       downstream accepts m_data
//   fifo_level    words currently stored
//   drop_cnt      saturating count of dropped events
module spike_event_packer #(
  parameter int NUM_CH            = 32,
  parameter int DEPTH             = 16,
  parameter int MAX_EVT_PER_FRAME = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                ch_idx,
  input  logic                      ch_valid,
  input  logic                      spk_flag,
  input  logic signed [15:0]        spk_amp,
  input  logic [31:0]               frame_No,
  output logic [63:0]               m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic [15:0]               drop_cnt
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [8:0]     NUM_CH_L = 9'(NUM_CH);
  localparam logic [7:0]     MAX_EVT  = 8'(MAX_EVT_PER_FRAME);
  localparam logic [AW:0]    FULL_LVL = (AW+1)'(DEPTH);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic [31:0]   last_frame;
  logic [7:0]    evt_in_frame;
  logic          pend_limit;
  logic          pend_full;

  logic          cand;
  logic          frame_change;
  logic [7:0]    evt_eff;
  logic          limit_hit;
  logic          fifo_full;
  logic          rd_en;
  logic          wr_en;
  logic          drop;
  logic [63:0]   evt_word;

  // Input stage: classify the candidate and decide write/drop this cycle
  always_comb begin
    cand         = ch_valid && spk_flag && ({1'b0, ch_idx} < NUM_CH_L);
    frame_change = (frame_No != last_frame);
    // A new frame restarts the budget in the same cycle it is first seen
    evt_eff      = frame_change ? 8'd0 : evt_in_frame;
    limit_hit    = (evt_eff >= MAX_EVT);
    rd_en        = (level != '0) && m_ready;
    fifo_full    = (level == FULL_LVL);
    // A read in the same cycle frees the slot the write needs
    wr_en        = !rst && cand && !limit_hit && !(fifo_full && !rd_en);
    drop         = cand && !wr_en;
    evt_word     = {frame_No, ch_idx, 6'd0, pend_limit, pend_full, spk_amp};
  end

  // Storage: data array is not reset, validity is tracked by level
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= evt_word;
  end

  // Control state
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      last_frame   <= '0;
      evt_in_frame <= '0;
      pend_limit   <= 1'b0;
      pend_full    <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      last_frame <= frame_No;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !rd_en)      level <= level + 1'b1;
      else if (rd_en && !wr_en) level <= level - 1'b1;
      evt_in_frame <= wr_en ? evt_eff + 8'd1 : evt_eff;
      if (wr_en) begin
        pend_limit <= 1'b0;
        pend_full  <= 1'b0;
      end else if (drop) begin
        if (limit_hit) pend_limit <= 1'b1;
        else           pend_full  <= 1'b1;
      end
      if (drop) drop_cnt <= sat_inc16(drop_cnt);
    end
  end

  // Output stage: fall-through head word, forced to zero while empty
  always_comb begin
    m_valid    = (level != '0);
    m_data     = m_valid ? mem[rd_ptr] : 64'd0;
    fifo_level = level;
  end

endmodule

// File: tb/tb_spike_event_packer.sv
module tb_spike_event_packer;

  logic               clk = 1'b0;
  logic               rst;
  logic [7:0]         ch_idx;
  logic               ch_valid;
  logic               spk_flag;
  logic signed [15:0] spk_amp;
  logic [31:0]        frame_No;
  logic [63:0]        m_data;
  logic               m_valid;
  logic               m_ready;
  logic [4:0]         fifo_level;
  logic [15:0]        drop_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  spike_event_packer #(
    .NUM_CH(32), .DEPTH(16), .MAX_EVT_PER_FRAME(8)
  ) dut (
    .clk(clk), .rst(rst), .ch_idx(ch_idx), .ch_valid(ch_valid),
    .spk_flag(spk_flag), .spk_amp(spk_amp), .frame_No(frame_No),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .fifo_level(fifo_level), .drop_cnt(drop_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic spike(input logic [7:0] ch, input logic [15:0] amp);
    ch_valid = 1'b1;
    spk_flag = 1'b1;
    ch_idx   = ch;
    spk_amp  = amp;
  endtask

  task automatic idle();
    ch_valid = 1'b0;
    spk_flag = 1'b0;
  endtask

  function automatic logic [63:0] word(input logic [31:0] f, input logic [7:0] ch,
                                       input logic lim, input logic full,
                                       input logic [15:0] amp);
    return {f, ch, 6'b0, lim, full, amp};
  endfunction

  logic [63:0] exp_q [17];
  logic [63:0] last_w;
  int          nwords;

  initial begin
    rst = 1'b1; ch_idx = '0; ch_valid = 1'b0; spk_flag = 1'b0;
    spk_amp = '0; frame_No = 32'd5; m_ready = 1'b0;
    step(); step();
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_drop",  64'(drop_cnt), 64'd0);
    check("rst_data",  m_data, 64'd0);
    rst = 1'b0;
    step();

    // Single event
    m_ready = 1'b1;
    spike(8'd3, 16'h00A0);
    step();
    idle();
    check("single_valid", 64'(m_valid), 64'd1);
    check("single_data",  m_data, 64'h00000005_030000A0);
    check("single_level", 64'(fifo_level), 64'd1);
    step();
    check("single_drain", 64'(fifo_level), 64'd0);

    // Per-frame limit: 10 spikes in frame 7
    frame_No = 32'd7;
    nwords = 0;
    for (int i = 0; i < 10; i++) begin
      spike(8'(i), 16'(i));
      step();
      if (m_valid) begin nwords++; last_w = m_data; end
    end
    idle();
    step();
    if (m_valid) nwords++;
    check("limit_words", 64'(nwords), 64'd8);
    check("limit_drop",  64'(drop_cnt), 64'd2);
    check("limit_last",  last_w, word(32'd7, 8'd7, 1'b0, 1'b0, 16'd7));

    // Frame 8: first word carries the limit flag, budget restarts
    frame_No = 32'd8;
    spike(8'd1, 16'h0055);
    step();
    check("limit_flag", m_data, word(32'd8, 8'd1, 1'b1, 1'b0, 16'h0055));
    nwords = 1;
    for (int i = 1; i < 8; i++) begin
      spike(8'(10 + i), 16'(10 + i));
      step();
      if (m_valid) begin nwords++; last_w = m_data; end
    end
    idle();
    step();
    check("restart_words", 64'(nwords), 64'd8);
    check("restart_drop",  64'(drop_cnt), 64'd2);
    check("restart_last",  last_w, word(32'd8, 8'd17, 1'b0, 1'b0, 16'd17));
    check("restart_empty", 64'(fifo_level), 64'd0);

    // Full with backpressure: 17 events over frames 10..12
    m_ready = 1'b0;
    for (int k = 0; k < 17; k++) begin
      frame_No = 32'(10 + k / 6);
      exp_q[k] = word(frame_No, 8'(k), 1'b0, 1'b0, 16'(16'h0100 + k));
      spike(8'(k), 16'(16'h0100 + k));
      step();
    end
    idle();
    check("full_level", 64'(fifo_level), 64'd16);
    check("full_drop",  64'(drop_cnt), 64'd3);
    check("full_stall", m_data, exp_q[0]);
    step();
    check("full_stable", m_data, exp_q[0]);
    m_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("full_order%0d", k), m_data, exp_q[k]);
      step();
    end
    check("full_drained", 64'(fifo_level), 64'd0);
    spike(8'd20, 16'h1234);
    step();
    idle();
    check("full_flag", m_data, word(32'd12, 8'd20, 1'b0, 1'b1, 16'h1234));
    step();

    // Full plus simultaneous read
    m_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      frame_No = 32'(20 + k / 8);
      spike(8'(k), 16'(k));
      step();
    end
    idle();
    check("fill_level", 64'(fifo_level), 64'd16);
    frame_No = 32'd22;
    spike(8'd5, 16'h7777);
    m_ready = 1'b1;
    step();
    idle();
    check("simul_level", 64'(fifo_level), 64'd16);
    check("simul_drop",  64'(drop_cnt), 64'd3);
    check("simul_head",  m_data, word(32'd20, 8'd1, 1'b0, 1'b0, 16'd1));
    for (int k = 0; k < 15; k++) step();
    check("simul_new", m_data, word(32'd22, 8'd5, 1'b0, 1'b0, 16'h7777));
    step();
    check("simul_empty", 64'(fifo_level), 64'd0);

    // Marker and out-of-range slots
    spike(8'd32, 16'h0001);
    step();
    check("marker_valid", 64'(m_valid), 64'd0);
    spike(8'd40, 16'h0002);
    step();
    idle();
    check("oor_level", 64'(fifo_level), 64'd0);
    check("oor_drop",  64'(drop_cnt), 64'd3);

    // Reset mid-operation
    m_ready = 1'b0;
    frame_No = 32'd30;
    for (int k = 0; k < 5; k++) begin
      spike(8'(k), 16'(k));
      step();
    end
    check("pre_rst_level", 64'(fifo_level), 64'd5);
    spike(8'd2, 16'h2222);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    check("mid_rst_valid", 64'(m_valid), 64'd0);
    check("mid_rst_level", 64'(fifo_level), 64'd0);
    check("mid_rst_drop",  64'(drop_cnt), 64'd0);
    check("mid_rst_data",  m_data, 64'd0);
    step();
    check("post_rst_valid", 64'(m_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
